nos_dac_half_rx: RTL and testbench
==================================

Name: nos_dac_half_rx

Overview:
- Receiver/deserializer for the NOS DAC half-mode serial bus (bck, data_l, data_r, le).
- Samples both channels MSB-first on bck rising edges and latches a frame on the le rising edge.
- Delivers a parallel stereo word in the same packing as the transceiver's input: high word is left, low word is right, left-justified in I2S_BITS slots.
- Used for loopback self-test of the NOS output path and for accepting an external NOS-format source.

Parameters:
- SYNC_STAGES, 2, number of flops on each of bck/data_l/data_r/le before edge detection. Legal values 0..3; 0 means the inputs are already in the clk domain, e.g. loopback from the transmitter.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- bck  input  1  serial bit clock from the bus
- data_l  input  1  left channel serial data
- data_r  input  1  right channel serial data
- le  input  1  latch enable; a rising edge ends the frame
- nos_bitnum  input  NOS_BITNUM  word length: NOS16/NOS18/NOS20/NOS24
- data  output  I2S_BITS*2  [63:32] left, [31:0] right, left-justified, zero-padded LSBs
- valid  output  1  one-cycle pulse when data/frame_err update
- frame_err  output  1  the latched frame had fewer than N bits
- bits_rcvd  output  6  bits counted in the last latched frame, saturating at 63

Behaviour:
- Reset is asynchronous, resetn low:
  - data=0, valid=0, frame_err=0, bits_rcvd=0
  - shift registers=0, bit counter=0, sync/edge flops=0
  - state=IDLE
- Synchronization:
  - Inputs pass through SYNC_STAGES flops, then one "previous" register per signal.
  - bck_rise = bck_s & !bck_p; le_rise = le_s & !le_p; le_fall = !le_s & le_p.
  - For SYNC_STAGES>0, each input level must last at least 2 clk periods.
- N is 16/18/20/24 per nos_bitnum, sampled at the le_rise cycle.
- Shift registers sr_l, sr_r are 24 bits: on a shift, sr <= {sr[22:0], data_s}.
- FSM states IDLE, SHIFT, LATCH:
  - IDLE: bck_rise & !le_s → shift, count=1, go SHIFT. le_rise → go LATCH with a capture (empty frame).
  - SHIFT: bck_rise & !le_s → shift, count=min(count+1,63). le_rise → capture, go LATCH.
  - LATCH: all bck_rise ignored. le_fall → clear sr_l/sr_r and count, go IDLE.
- Capture happens in the same clk edge as the registered le_rise decision:
  - data[63:32] = {sr_l[N-1:0], (32-N)'b0}
  - data[31:0] = {sr_r[N-1:0], (32-N)'b0}
  - frame_err = (count < N); bits_rcvd = count; valid=1 for exactly one cycle.
- Dummy-clock handling:
  - Frames carrying more than N clocks (bck_cont leading dummy zero bits) keep only the last N bits.
  - frame_err=0 for these frames.
- Short frame: missing MSBs are zero because the registers are cleared at frame start.
- bck_rise and le_rise in the same cycle: le wins and that bit is not shifted.
- data, frame_err and bits_rcvd hold until the next capture.
- Latency: with SYNC_STAGES=0, valid is high in the cycle after the first clk edge that samples le high. Each sync stage adds one cycle.
- Reset mid-frame aborts the partial frame with no valid. The next complete frame decodes normally.
- Back-to-back frames are supported: le falls, then bck resumes immediately.

Test Plan:
- Loopback with SYNC_STAGES=0 from the half-mode transmitter, NOS16, bck_cont=0, input 64'hA5A5xxxx_5A5Axxxx → one valid pulse, data=64'hA5A50000_5A5A0000, frame_err=0, bits_rcvd=16.
- Loopback NOS24, bck_cont=1, input left[63:40]=24'h123456, right[31:8]=24'hABCDEF → data=64'h12345600_ABCDEF00, frame_err=0, bits_rcvd=31 (7 dummy + 24).
- NOS18 direct drive with SYNC_STAGES=2, bck period 8 clk, 18 bits left=18'h2AAAA, right=18'h15555, then le high → data=64'hAAAA8000_55554000, valid exactly one cycle, 3 cycles after le is first sampled high.
- Short frame: NOS16, 10 bits of all-ones on both channels, then le → data=64'h03FF0000_03FF0000, frame_err=1, bits_rcvd=10.
- Extra bck rises while le is high, and bck_rise coincident with le_rise → those bits are ignored, and the next frame decodes correctly.
- resetn pulsed low after 8 bits of a 16-bit frame → all outputs 0 and no valid. A following full frame 16'h8001/16'h7FFE gives data=64'h80010000_7FFE0000.

Source files
------------

// File: rtl/nos_dac_half_rx.sv
// NOS DAC half-mode serial receiver: deserializes bck/data_l/data_r/le into a
// left-justified stereo word, with optional input synchronizers.
`timescale 1ns/1ps

package nos_dac_half_rx_pkg;
    localparam int I2S_BITS = 32;

    typedef enum logic [1:0] {
        NOS16 = 2'd0,
        NOS18 = 2'd1,
        NOS20 = 2'd2,
        NOS24 = 2'd3
    } nos_bitnum_t;
endpackage

module nos_dac_half_rx
    import nos_dac_half_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    bck,
    input  logic                    data_l,
    input  logic                    data_r,
    input  logic                    le,
    input  nos_bitnum_t             nos_bitnum,
    output logic [I2S_BITS*2-1:0]   data,
    output logic                    valid,
    output logic                    frame_err,
    output logic [5:0]              bits_rcvd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    logic [3:0] in_raw;
    logic [3:0] in_syn;
    logic       bck_s, data_l_s, data_r_s, le_s;
    logic       bck_p, le_p;
    logic       bck_rise, le_rise, le_fall;

    state_t     state, state_next;
    logic       do_shift, do_start, do_capture, do_clear;

    logic [23:0] sr_l, sr_r;
    logic [5:0]  count;
    logic [5:0]  n_bits;

    assign in_raw = {bck, data_l, data_r, le};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign in_syn = in_raw;
        end else begin : g_sync
            logic [3:0] stage [SYNC_STAGES];

            // NOTE: sequential state uses <= so every flop samples the pre-edge value of its neighbour.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= in_raw;
                    for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
                end
            end

            assign in_syn = stage[SYNC_STAGES-1];
        end
    endgenerate

    assign {bck_s, data_l_s, data_r_s, le_s} = in_syn;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bck_p <= 1'b0;
            le_p  <= 1'b0;
        end else begin
            bck_p <= bck_s;
            le_p  <= le_s;
        end
    end

    assign bck_rise = bck_s & ~bck_p;
    assign le_rise  = le_s & ~le_p;
    assign le_fall  = ~le_s & le_p;

    always_comb begin
        n_bits = 6'd24;
        case (nos_bitnum)
            NOS16:   n_bits = 6'd16;
            NOS18:   n_bits = 6'd18;
            NOS20:   n_bits = 6'd20;
            default: n_bits = 6'd24;
        endcase
    end

    // Keep the newest N bits and left-justify them in a 32-bit slot.
    function automatic logic [I2S_BITS-1:0] justify(input logic [23:0] sr, input nos_bitnum_t sel);
        case (sel)
            NOS16:   return {sr[15:0], 16'b0};
            NOS18:   return {sr[17:0], 14'b0};
            NOS20:   return {sr[19:0], 12'b0};
            default: return {sr[23:0], 8'b0};
        endcase
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (le_rise)                state_next = LATCH;
                else if (bck_rise && !le_s) state_next = SHIFT;
            end
            SHIFT: begin
                if (le_rise) state_next = LATCH;
            end
            LATCH: begin
                if (le_fall) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A latch edge takes priority over a coincident bit clock edge.
    always_comb begin
        do_shift   = 1'b0;
        do_start   = 1'b0;
        do_capture = 1'b0;
        do_clear   = 1'b0;
        case (state)
            IDLE: begin
                if (le_rise) begin
                    do_capture = 1'b1;
                end else if (bck_rise && !le_s) begin
                    do_shift = 1'b1;
                    do_start = 1'b1;
                end
            end
            SHIFT: begin
                if (le_rise)                do_capture = 1'b1;
                else if (bck_rise && !le_s) do_shift   = 1'b1;
            end
            LATCH: begin
                if (le_fall) do_clear = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr_l      <= '0;
            sr_r      <= '0;
            count     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            bits_rcvd <= '0;
        end else begin
            valid <= do_capture;

            if (do_capture) begin
                data      <= {justify(sr_l, nos_bitnum), justify(sr_r, nos_bitnum)};
                frame_err <= (count < n_bits);
                bits_rcvd <= count;
            end

            if (do_clear) begin
                sr_l  <= '0;
                sr_r  <= '0;
                count <= '0;
            end else if (do_shift) begin
                sr_l <= {sr_l[22:0], data_l_s};
                sr_r <= {sr_r[22:0], data_r_s};
                if (do_start)             count <= 6'd1;
                else if (count != 6'd63)  count <= count + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_nos_dac_half_rx.sv
// Self-checking bench for nos_dac_half_rx: two instances (SYNC_STAGES 0 and 2)
// share one serial bus and are checked against a bit-count arithmetic model.
`timescale 1ns/1ps

module tb_nos_dac_half_rx;
    import nos_dac_half_rx_pkg::*;

    typedef struct {
        logic [63:0] d;
        logic        e;
        logic [5:0]  b;
        int          c;
    } cap_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        bck, data_l, data_r, le;
    nos_bitnum_t nos_bitnum;

    logic [63:0] d_o [2];
    logic        v_o [2];
    logic        e_o [2];
    logic [5:0]  b_o [2];

    int   cyc = 0;
    int   le_cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    cap_t caps [2][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++)
            if (v_o[k] === 1'b1) caps[k].push_back('{d_o[k], e_o[k], b_o[k], cyc});
    end

    nos_dac_half_rx #(.SYNC_STAGES(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .bck(bck), .data_l(data_l), .data_r(data_r), .le(le),
        .nos_bitnum(nos_bitnum), .data(d_o[0]), .valid(v_o[0]), .frame_err(e_o[0]), .bits_rcvd(b_o[0])
    );

    nos_dac_half_rx #(.SYNC_STAGES(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .bck(bck), .data_l(data_l), .data_r(data_r), .le(le),
        .nos_bitnum(nos_bitnum), .data(d_o[1]), .valid(v_o[1]), .frame_err(e_o[1]), .bits_rcvd(b_o[1])
    );

    function automatic int word_len(input nos_bitnum_t nb);
        case (nb)
            NOS16:   return 16;
            NOS18:   return 18;
            NOS20:   return 20;
            default: return 24;
        endcase
    endfunction

    // Expected capture: last N of the bits actually sent, left-justified; count saturates at 63.
    function automatic cap_t model(input logic [79:0] lb, input logic [79:0] rb,
                                   input int nbits, input nos_bitnum_t nb);
        cap_t        m;
        int          n;
        int          cnt;
        logic [79:0] sent_mask, keep_mask, kl, kr;
        logic [31:0] wl, wr;
        n         = word_len(nb);
        cnt       = (nbits > 63) ? 63 : nbits;
        sent_mask = (80'd1 << nbits) - 80'd1;
        keep_mask = (80'd1 << n) - 80'd1;
        kl        = (lb & sent_mask & keep_mask) << (32 - n);
        kr        = (rb & sent_mask & keep_mask) << (32 - n);
        wl        = kl[31:0];
        wr        = kr[31:0];
        m.d = {wl, wr};
        m.e = (cnt < n);
        m.b = 6'(cnt);
        m.c = 0;
        return m;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [79:0] lb, input logic [79:0] rb, input int nbits, input int half);
        for (int i = nbits - 1; i >= 0; i--) begin
            data_l = lb[i];
            data_r = rb[i];
            bck    = 1'b0;
            tick(half);
            bck    = 1'b1;
            tick(half);
        end
        bck = 1'b0;
        tick(half);
    endtask

    // Raise le (optionally with a coincident bck edge), toggle bck while le is high, then drop le.
    task automatic latch_frame(input bit coincide, input int extra);
        if (coincide) begin
            data_l = 1'b1;
            data_r = 1'b1;
            bck    = 1'b1;
        end
        le     = 1'b1;
        le_cyc = cyc;
        tick(3);
        bck = 1'b0;
        tick(3);
        for (int i = 0; i < extra; i++) begin
            bck    = 1'b1;
            data_l = ~data_l;
            tick(3);
            bck = 1'b0;
            tick(3);
        end
        le = 1'b0;
        tick(1);
    endtask

    task automatic run_frame(input logic [79:0] lb, input logic [79:0] rb, input int nbits,
                             input int half, input bit coincide, input int extra);
        caps[0].delete();
        caps[1].delete();
        send_bits(lb, rb, nbits, half);
        latch_frame(coincide, extra);
        tick(3);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bck = 1'b0; data_l = 1'b0; data_r = 1'b0; le = 1'b0;
        nos_bitnum = NOS16;
        tick(3);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (d_o[k] !== 64'd0 || v_o[k] !== 1'b0 || e_o[k] !== 1'b0 || b_o[k] !== 6'd0) begin
                n_errors++;
                $display("FAIL reset_state dut%0d: got d=%h v=%b e=%b b=%0d want all zero",
                         k, d_o[k], v_o[k], e_o[k], b_o[k]);
            end
        end
        resetn = 1'b1;
        tick(4);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (caps[k].size() != 0) begin
                n_errors++;
                $display("FAIL reset_no_valid dut%0d: got %0d pulses want 0", k, caps[k].size());
            end
        end
    endtask

    task automatic test_loopback16();
        cap_t exp;
        nos_bitnum = NOS16;
        exp = model(80'hA5A5, 80'h5A5A, 16, NOS16);
        run_frame(80'hA5A5, 80'h5A5A, 16, 4, 1'b0, 0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (caps[k].size() != 1) begin
                n_errors++;
                $display("FAIL nos16_pulses dut%0d: got %0d want 1", k, caps[k].size());
            end else begin
                n_checks++;
                if (caps[k][0].d !== 64'hA5A50000_5A5A0000 || caps[k][0].e !== 1'b0 || caps[k][0].b !== 6'd16
                    || caps[k][0].d !== exp.d) begin
                    n_errors++;
                    $display("FAIL nos16_frame dut%0d: got d=%h e=%b b=%0d want d=a5a500005a5a0000 e=0 b=16",
                             k, caps[k][0].d, caps[k][0].e, caps[k][0].b);
                end
                n_checks++;
                if (caps[k][0].c - le_cyc != 2 * k + 1) begin
                    n_errors++;
                    $display("FAIL nos16_latency dut%0d: got %0d want %0d", k, caps[k][0].c - le_cyc, 2 * k + 1);
                end
            end
        end
    endtask

    task automatic test_dummy_clocks24();
        logic [79:0] lb, rb;
        nos_bitnum = NOS24;
        lb = 80'h123456;
        rb = 80'hABCDEF;
        run_frame(lb, rb, 31, 3, 1'b0, 0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (caps[k].size() != 1) begin
                n_errors++;
                $display("FAIL nos24_pulses dut%0d: got %0d want 1", k, caps[k].size());
            end else begin
                n_checks++;
                if (caps[k][0].d !== 64'h12345600_ABCDEF00 || caps[k][0].e !== 1'b0 || caps[k][0].b !== 6'd31) begin
                    n_errors++;
                    $display("FAIL nos24_dummy dut%0d: got d=%h e=%b b=%0d want d=12345600abcdef00 e=0 b=31",
                             k, caps[k][0].d, caps[k][0].e, caps[k][0].b);
                end
            end
        end
    endtask

    task automatic test_nos18();
        nos_bitnum = NOS18;
        run_frame(80'h2AAAA, 80'h15555, 18, 4, 1'b0, 0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (caps[k].size() != 1) begin
                n_errors++;
                $display("FAIL nos18_pulses dut%0d: got %0d want 1", k, caps[k].size());
            end else begin
                n_checks++;
                if (caps[k][0].d !== 64'hAAAA8000_55554000 || caps[k][0].e !== 1'b0 || caps[k][0].b !== 6'd18) begin
                    n_errors++;
                    $display("FAIL nos18_frame dut%0d: got d=%h e=%b b=%0d want d=aaaa800055554000 e=0 b=18",
                             k, caps[k][0].d, caps[k][0].e, caps[k][0].b);
                end
                n_checks++;
                if (caps[k][0].c - le_cyc != 2 * k + 1) begin
                    n_errors++;
                    $display("FAIL nos18_latency dut%0d: got %0d want %0d", k, caps[k][0].c - le_cyc, 2 * k + 1);
                end
            end
        end
    endtask

    task automatic test_short_frame();
        nos_bitnum = NOS16;
        run_frame(80'h3FF, 80'h3FF, 10, 2, 1'b0, 0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (caps[k].size() != 1) begin
                n_errors++;
                $display("FAIL short_pulses dut%0d: got %0d want 1", k, caps[k].size());
            end else begin
                n_checks++;
                if (caps[k][0].d !== 64'h03FF0000_03FF0000 || caps[k][0].e !== 1'b1 || caps[k][0].b !== 6'd10) begin
                    n_errors++;
                    $display("FAIL short_frame dut%0d: got d=%h e=%b b=%0d want d=03ff000003ff0000 e=1 b=10",
                             k, caps[k][0].d, caps[k][0].e, caps[k][0].b);
                end
            end
        end
    endtask

    task automatic test_le_collisions();
        cap_t        exp;
        logic [79:0] lb, rb;
        nos_bitnum = NOS20;
        for (int f = 0; f < 2; f++) begin
            lb = 80'($urandom());
            rb = 80'($urandom());
            exp = model(lb, rb, 20, NOS20);
            // First frame: coincident bck/le edge plus extra bck while le is high; second decodes cleanly.
            run_frame(lb, rb, 20, 3, (f == 0), (f == 0) ? 3 : 0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (caps[k].size() != 1) begin
                    n_errors++;
                    $display("FAIL collide%0d_pulses dut%0d: got %0d want 1", f, k, caps[k].size());
                end else begin
                    n_checks++;
                    if (caps[k][0].d !== exp.d || caps[k][0].e !== exp.e || caps[k][0].b !== exp.b) begin
                        n_errors++;
                        $display("FAIL collide%0d_frame dut%0d: got d=%h e=%b b=%0d want d=%h e=%b b=%0d",
                                 f, k, caps[k][0].d, caps[k][0].e, caps[k][0].b, exp.d, exp.e, exp.b);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        nos_bitnum = NOS16;
        caps[0].delete();
        caps[1].delete();
        send_bits(80'hFF, 80'hC3, 8, 3);
        resetn = 1'b0;
        tick(2);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (d_o[k] !== 64'd0 || v_o[k] !== 1'b0 || e_o[k] !== 1'b0 || b_o[k] !== 6'd0) begin
                n_errors++;
                $display("FAIL midreset_state dut%0d: got d=%h v=%b e=%b b=%0d want all zero",
                         k, d_o[k], v_o[k], e_o[k], b_o[k]);
            end
        end
        resetn = 1'b1;
        tick(4);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (caps[k].size() != 0) begin
                n_errors++;
                $display("FAIL midreset_no_valid dut%0d: got %0d pulses want 0", k, caps[k].size());
            end
        end
        run_frame(80'h8001, 80'h7FFE, 16, 4, 1'b0, 0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (caps[k].size() != 1) begin
                n_errors++;
                $display("FAIL midreset_next_pulses dut%0d: got %0d want 1", k, caps[k].size());
            end else begin
                n_checks++;
                if (caps[k][0].d !== 64'h80010000_7FFE0000 || caps[k][0].e !== 1'b0 || caps[k][0].b !== 6'd16) begin
                    n_errors++;
                    $display("FAIL midreset_next_frame dut%0d: got d=%h e=%b b=%0d want d=800100007ffe0000 e=0 b=16",
                             k, caps[k][0].d, caps[k][0].e, caps[k][0].b);
                end
            end
        end
    endtask

    // Back-to-back random frames: random word length, bit count (incl. empty and >63), bck rate.
    task automatic test_back_to_back();
        cap_t        exp;
        logic [79:0] lb, rb;
        int          nbits, n;
        int          edge_cases [6];
        for (int i = 0; i < 24; i++) begin
            nos_bitnum = nos_bitnum_t'($urandom_range(0, 3));
            n = word_len(nos_bitnum);
            edge_cases = '{0, n - 1, n, n + 1, 63, 70};
            nbits = (i < 6) ? edge_cases[i] : int'($urandom_range(0, 40));
            lb = {16'($urandom()), 32'($urandom()), 32'($urandom())};
            rb = {16'($urandom()), 32'($urandom()), 32'($urandom())};
            exp = model(lb, rb, nbits, nos_bitnum);
            run_frame(lb, rb, nbits, int'($urandom_range(2, 5)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)));
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (caps[k].size() != 1) begin
                    n_errors++;
                    $display("FAIL b2b%0d_pulses dut%0d: got %0d want 1", i, k, caps[k].size());
                end else begin
                    n_checks++;
                    if (caps[k][0].d !== exp.d || caps[k][0].e !== exp.e || caps[k][0].b !== exp.b) begin
                        n_errors++;
                        $display("FAIL b2b%0d_frame dut%0d (nbits=%0d N=%0d): got d=%h e=%b b=%0d want d=%h e=%b b=%0d",
                                 i, k, nbits, n, caps[k][0].d, caps[k][0].e, caps[k][0].b, exp.d, exp.e, exp.b);
                    end
                end
                n_checks++;
                if (d_o[k] !== exp.d || e_o[k] !== exp.e || b_o[k] !== exp.b || v_o[k] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL b2b%0d_hold dut%0d: got d=%h e=%b b=%0d v=%b want d=%h e=%b b=%0d v=0",
                             i, k, d_o[k], e_o[k], b_o[k], v_o[k], exp.d, exp.e, exp.b);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_loopback16();
        test_dummy_clocks24();
        test_nos18();
        test_short_frame();
        test_le_collisions();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
